// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - host handshake and control-FSM signal bundle for the instruction sequencer
interface instr_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_func;
    logic [2:0]        in_rx;
    logic [2:0]        in_ry;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        func;
    logic [2:0]        input1;
    logic [2:0]        input2;
    logic [DATA_W-1:0] data_bus;
    logic [4:0]        current_state;
    logic [4:0]        next_state;
    logic              busy;
    logic              done;
    logic              illegal;
    logic              fault;

    modport master (
        output in_valid, in_func, in_rx, in_ry, in_data, next_state,
        input  in_ready, func, input1, input2, data_bus, current_state,
        input  busy, done, illegal, fault
    );

    modport slave (
        input  in_valid, in_func, in_rx, in_ry, in_data, next_state,
        output in_ready, func, input1, input2, data_bus, current_state,
        output busy, done, illegal, fault
    );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction FIFO plus issue FSM that owns current_state for the control FSM
module instr_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                resetn,
    instr_sequencer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 10 + DATA_W;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_count;
    state_t            r_state;
    logic [3:0]        r_func;
    logic [2:0]        r_rx, r_ry;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_step;
    logic [4:0]        r_cur_state;
    logic              r_busy, r_done, r_illegal, r_fault;

    logic              w_full, w_empty, w_push, w_pop;
    logic [EW-1:0]     w_head;
    logic [3:0]        w_head_func;
    logic              w_head_legal, w_short, w_last, w_abort, w_end;

    assign w_full       = (r_count == CNT_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = bus.in_valid && !w_full;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_func  = w_head[EW-1 -: 4];
    assign w_head_legal = (w_head_func >= 4'd1) && (w_head_func <= 4'd9);

    // Load and move finish in one step; every ALU op takes three.
    assign w_short = (r_func == 4'd1) || (r_func == 4'd2);
    assign w_last  = (r_step == (w_short ? 2'd0 : 2'd2));
    assign w_abort = !w_last && (bus.next_state == 5'd0);
    assign w_end   = (r_state == EXEC) && (w_last || w_abort);
    assign w_pop   = !w_empty && ((r_state == IDLE) || w_end);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_func, bus.in_rx, bus.in_ry, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_func      <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_data      <= '0;
            r_step      <= '0;
            r_cur_state <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
            if ((r_state == EXEC) && !w_end) begin
                r_cur_state <= bus.next_state;
                r_step      <= r_step + 2'd1;
            end else begin
                // Idle, or the edge that closes the running instruction: decide the next one here.
                if (r_state == EXEC) begin
                    r_done  <= w_last;
                    r_fault <= !w_last;
                end
                r_step      <= '0;
                r_cur_state <= '0;
                if (w_pop && w_head_legal) begin
                    r_state <= EXEC;
                    r_busy  <= 1'b1;
                    r_func  <= w_head_func;
                    r_rx    <= w_head[EW-5 -: 3];
                    r_ry    <= w_head[EW-8 -: 3];
                    r_data  <= (w_head_func == 4'd1) ? w_head[DATA_W-1:0] : '0;
                end else begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_func    <= '0;
                    r_rx      <= '0;
                    r_ry      <= '0;
                    r_data    <= '0;
                    r_illegal <= w_pop;
                end
            end
        end
    end

    assign bus.in_ready      = !w_full;
    assign bus.func          = r_func;
    assign bus.input1        = r_rx;
    assign bus.input2        = r_ry;
    assign bus.data_bus      = r_data;
    assign bus.current_state = r_cur_state;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.illegal       = r_illegal;
    assign bus.fault         = r_fault;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized scoreboard bench for instr_sequencer
module tb_instr_sequencer;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    typedef struct {
        logic [3:0] f;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] d;
    } instr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    instr_sequencer_if #(.DATA_W(DATA_W)) sif ();
    instr_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    always #5 clk = ~clk;

    // Control-FSM stand-in: ALU ops walk 00011 then 00100; ry==6 / ry==7 return 00000 early.
    always_comb begin
        sif.next_state = 5'd0;
        if (sif.busy && sif.func >= 4'd3 && sif.func <= 4'd9) begin
            case (sif.current_state)
                5'd0:    sif.next_state = (sif.input2 == 3'd6) ? 5'd0 : 5'b00011;
                5'b00011: sif.next_state = (sif.input2 == 3'd7) ? 5'd0 : 5'b00100;
                default: sif.next_state = 5'd0;
            endcase
        end else if (sif.busy) begin
            sif.next_state = {2'b00, sif.input1};
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] f);
        return (f >= 4'd1) && (f <= 4'd9);
    endfunction

    function automatic int nominal_len(input instr_t h);
        return (h.f == 4'd1 || h.f == 4'd2) ? 1 : 3;
    endfunction

    function automatic int exp_len(input instr_t h);
        if (nominal_len(h) == 1) return 1;
        if (h.ry == 3'd6) return 1;
        if (h.ry == 3'd7) return 2;
        return 3;
    endfunction

    function automatic int exp_cs(input int step);
        return (step == 0) ? 0 : (step == 1) ? 3 : 4;
    endfunction

    instr_t exp_q[$];
    instr_t cur;
    int  n_push = 0;
    int  n_pop = 0;
    int  cur_step = 0;
    int  cur_len = 0;
    bit  cur_active = 0;
    bit  end_pending = 0;
    bit  end_fault = 0;
    bit  exp_ill = 0;
    bit  exp_start = 0;
    bit  saw_full = 0;

    always @(negedge clk) begin
        instr_t h;
        int avail;
        bit started;
        if (!resetn) begin
            exp_q.delete();
            n_push = 0; n_pop = 0;
            cur_active = 0; end_pending = 0; end_fault = 0;
            exp_ill = 0; exp_start = 0;
        end else begin
            chk("done", sif.done, end_pending && !end_fault);
            chk("fault", sif.fault, end_pending && end_fault);
            end_pending = 0;
            chk("illegal", sif.illegal, exp_ill);
            if (sif.illegal) begin
                if (exp_q.size() == 0) chk("illegal_queue", 0, 1);
                else begin
                    h = exp_q.pop_front();
                    n_pop++;
                    chk("illegal_op", legal(h.f), 0);
                end
            end
            started = sif.busy && !cur_active;
            chk("start", started, exp_start);
            if (sif.busy) begin
                if (!cur_active) begin
                    if (exp_q.size() == 0) begin
                        chk("start_queue", 0, 1);
                        cur = '{4'd0, 3'd0, 3'd0, 8'd0};
                    end else begin
                        cur = exp_q.pop_front();
                        n_pop++;
                    end
                    chk("start_legal", legal(cur.f), 1);
                    cur_step = 0;
                    cur_len = exp_len(cur);
                    cur_active = 1;
                end
                chk("func", sif.func, cur.f);
                chk("input1", sif.input1, cur.rx);
                chk("input2", sif.input2, cur.ry);
                chk("data_bus", sif.data_bus, (cur.f == 4'd1) ? cur.d : 0);
                chk("current_state", sif.current_state, exp_cs(cur_step));
                cur_step++;
                if (cur_step >= cur_len) begin
                    cur_active = 0;
                    end_pending = 1;
                    end_fault = cur_len < nominal_len(cur);
                end
            end else begin
                chk("busy_held", sif.busy, cur_active);
                cur_active = 0;
                chk("idle_outputs", {sif.func, sif.input1, sif.input2, sif.data_bus, sif.current_state}, 0);
            end
            avail = n_push - n_pop;
            chk("in_ready", sif.in_ready, avail < DEPTH);
            if (!sif.in_ready) saw_full = 1;
            exp_ill   = !cur_active && avail > 0 && !legal(exp_q[0].f);
            exp_start = !cur_active && avail > 0 && legal(exp_q[0].f);
        end
    end

    // Called right after a falling edge; returns on the falling edge after acceptance.
    task automatic push(input logic [3:0] f, input logic [2:0] rx, input logic [2:0] ry, input logic [7:0] d);
        int w = 0;
        sif.in_valid = 1'b1;
        sif.in_func = f; sif.in_rx = rx; sif.in_ry = ry; sif.in_data = d;
        while (!sif.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!sif.in_ready) begin
            chk("push_timeout", 0, 1);
            sif.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back('{f, rx, ry, d});
        n_push++;
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        bit ok = 0;
        while (w < 1000 && !ok) begin
            @(negedge clk);
            #1;
            ok = (exp_q.size() == 0) && !cur_active && !end_pending && !sif.busy;
            w++;
        end
        chk("drain", ok, 1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] f;
        int w;
        sif.in_valid = 1'b0;
        sif.in_func = '0; sif.in_rx = '0; sif.in_ry = '0; sif.in_data = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_in_ready", sif.in_ready, 1);
        chk("reset_outputs", {sif.func, sif.input1, sif.input2, sif.data_bus, sif.current_state,
                              sif.busy, sif.done, sif.illegal, sif.fault}, 0);
        @(negedge clk);

        push(4'd1, 3'd3, 3'd0, 8'h5A);
        @(negedge clk);
        #1;
        chk("load_latency_busy", sif.busy, 1);
        chk("load_latency_func", sif.func, 1);
        chk("load_latency_data", sif.data_bus, 8'h5A);
        @(negedge clk);
        #1;
        chk("load_done", sif.done, 1);
        chk("load_busy_drop", sif.busy, 0);
        wait_idle();

        push(4'd3, 3'd1, 3'd2, 8'h00);
        wait_idle();

        saw_full = 0;
        for (int i = 0; i < 8; i++) push(4'd3 + 4'(i % 7), 3'(i), 3'd0, 8'(i));
        wait_idle();
        chk("fifo_filled", saw_full, 1);

        push(4'd15, 3'd1, 3'd1, 8'h00);
        push(4'd2, 3'd4, 3'd5, 8'h00);
        wait_idle();

        push(4'd4, 3'd1, 3'd7, 8'h00);
        push(4'd3, 3'd2, 3'd3, 8'h00);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom_range(0, 6);
                f = (w == 0) ? 4'd0 : 4'(9 + w);
            end else begin
                f = 4'($urandom_range(1, 9));
            end
            push(f, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            w = $urandom_range(0, 3);
            if (w == 3) repeat (3) @(negedge clk);
            else if (w == 2) @(negedge clk);
        end
        wait_idle();

        push(4'd5, 3'd1, 3'd2, 8'h00);
        push(4'd1, 3'd2, 3'd0, 8'h11);
        push(4'd3, 3'd3, 3'd4, 8'h00);
        w = 0;
        while (!(sif.busy && sif.func == 4'd5 && sif.current_state == 5'b00011) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("xor_step1_reached", sif.busy && sif.func == 4'd5 && sif.current_state == 5'b00011, 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_reset_outputs", {sif.func, sif.input1, sif.input2, sif.data_bus, sif.current_state,
                                    sif.busy, sif.done, sif.illegal, sif.fault}, 0);
        chk("async_reset_in_ready", sif.in_ready, 1);
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("post_reset_busy", sif.busy, 0);
        chk("post_reset_in_ready", sif.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction issue controller for the simple processor datapath. It accepts instructions from a host over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the combinational control FSM by driving `func`, `input1`, `input2` and the registered `current_state`, and signals completion. It owns the `current_state` register that the control FSM needs but does not hold.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DATA_W`, 8: width of the load immediate.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  host presents an instruction.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `in_func`  in  4  opcode: 0001 load, 0010 move, 0011 add, 0100 sub, 0101 xor, 0110 or, 0111 and, 1000 div, 1001 mod.
- `in_rx`  in  3  destination/first register number.
- `in_ry`  in  3  second register number.
- `in_data`  in  DATA_W  load immediate; ignored for other opcodes.
- `func`  out  4  opcode to the control FSM.
- `input1`, `input2`  out  3 each  register numbers to the control FSM.
- `data_bus`  out  DATA_W  immediate of the executing load; 0 otherwise.
- `current_state`  out  5  registered FSM state.
- `next_state`  in  5  next state returned by the control FSM.
- `busy`  out  1  instruction executing.
- `done`  out  1  one-cycle pulse after an instruction's last step.
- `illegal`  out  1  one-cycle pulse when a popped opcode is not in the legal set.
- `fault`  out  1  one-cycle pulse when `next_state` is 00000 before the final step.

## Operation
- FIFO stores {func, rx, ry, data}.
  - Push on `in_valid && in_ready`; pop is driven only by the issue FSM.
  - A push while full is impossible because `in_ready` is low.
  - A simultaneous push and pop when non-full keeps the count unchanged.
  - Pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
- Issue FSM states are IDLE and EXEC.
- IDLE:
  - `func`, `input1`, `input2` and `data_bus` are 0; `current_state` is 00000; `busy` is 0.
  - If the FIFO is non-empty, pop the head.
  - A legal opcode loads the instruction register, clears the step counter and `current_state`, and moves to EXEC.
  - An illegal opcode is discarded: pulse `illegal`, stay in IDLE, with one cycle consumed per discarded entry.
- Step count per opcode is 1 for load and move, 3 for the ALU ops (0011–1001).
- EXEC:
  - `busy` is 1, and the outputs are driven from the instruction register.
  - Each edge, `current_state <= next_state` and the step counter increments.
  - On the edge ending the final step, pulse `done` in the next cycle and force `current_state` to 00000.
  - On that same edge, if the FIFO is non-empty, pop the next instruction directly and stay in EXEC with no bubble. Otherwise go to IDLE.
  - An illegal head popped on that same edge is handled as in IDLE: pulse `illegal`, go to IDLE.
- If `next_state` is 00000 on a non-final step: pulse `fault`, abandon the instruction (no `done`), and take the same pop/IDLE decision as at a final step.
- `illegal` and `fault` are never asserted together with `done` for the same instruction.

## Timing
- Reset values:
  - FIFO empty; `in_ready` = 1; FSM in IDLE.
  - All other outputs 0, including `current_state` = 00000.
- Accept at edge k means the entry is in the FIFO after k.
  - From an empty, idle sequencer, the pop happens at edge k+1.
  - Step 0 is the cycle after k+1, so `func` is valid 2 cycles after the accepting edge.
- Load/move occupy 1 cycle, with `current_state` = 00000.
- An ALU op occupies 3 cycles, with `current_state` = 00000, S1, S2, where S1 and S2 come from the FSM (add: 00011, 00100).
- `done` is registered and appears in the cycle after the last step. It can coincide with step 0 of the next instruction.
- Back-to-back throughput: one instruction per step-count cycles, with no idle cycle between instructions.
- `in_ready` rises in the cycle after a pop frees a full FIFO.
- Asserting `resetn` low at any time immediately clears the FIFO, the FSM, all outputs and all pulses. Nothing in flight completes.

## Test plan
- Reset, then push load rx=3, data=0x5A:
  - `func`=0001, `input1`=3, `data_bus`=0x5A for 1 cycle, 2 cycles after accept.
  - `done` pulses the next cycle; `busy` returns to 0.
- Push add rx=1 ry=2 with the real control FSM attached:
  - `current_state` reads 00000, 00011, 00100 on 3 consecutive cycles.
  - `done` follows; no `fault`.
- Push 4 instructions while the first is executing:
  - The FIFO fills and `in_ready` goes 0.
  - Each finishing instruction frees a slot.
  - All complete in order with no bubble; 4 `done` pulses.
- Push func=1111, then move:
  - `illegal` pulses once.
  - The move issues on the next cycle; one `done`.
- Stub `next_state` to 00000 at step 1 of a sub:
  - `fault` pulses; no `done`.
  - The next queued op starts immediately.
- Drop `resetn` mid-step 1 of xor with 2 entries queued:
  - All outputs are 0 asynchronously.
  - After release the FIFO is empty and `in_ready` = 1.
